// File: rtl/mux_pkg.sv
// Shared constants and arbitration state type for the rr_select4 selector.
`default_nettype none

package mux_pkg;
  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sel_st_t;
endpackage

`default_nettype wire

// File: rtl/rr_pick4.sv
// rr_pick4: rotated priority encoder. The lowest offset from ptr with a valid request wins.
`default_nettype none

module rr_pick4
  import mux_pkg::*;
(
  input  logic [NCH-1:0]   in_valid,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  always_comb begin
    any = |in_valid;
    idx = ptr;
    // Scan from the farthest offset down so that the nearest requester overwrites the others.
    for (int off = NCH - 1; off >= 0; off--) begin
      if (in_valid[ptr + SEL_W'(off)]) begin
        idx = ptr + SEL_W'(off);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_select4.sv
// rr_select4: four-channel round-robin selector with a registered valid/ready output stage.
`default_nettype none

module rr_select4
  import mux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [NCH-1:0]   in_ready,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  sel_st_t          st, st_nxt;
  logic [SEL_W-1:0] ptr;
  logic             any;
  logic [SEL_W-1:0] idx;
  logic             cap;
  logic [WIDTH-1:0] win_data;

  rr_pick4 u_pick (
    .in_valid (in_valid),
    .ptr      (ptr),
    .any      (any),
    .idx      (idx)
  );

  // The reset term keeps in_ready low while reset is asserted, even with requests pending.
  always_comb begin
    cap      = any && !rst && ((st == IDLE) || out_ready);
    in_ready = '0;
    if (cap) begin
      in_ready[idx] = 1'b1;
    end

    win_data = in_data0;
    case (idx)
      2'd1:    win_data = in_data1;
      2'd2:    win_data = in_data2;
      2'd3:    win_data = in_data3;
      default: win_data = in_data0;
    endcase

    st_nxt = st;
    if (cap) begin
      st_nxt = BUSY;
    end else if ((st == BUSY) && out_ready) begin
      st_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  // sel and out_data move only on capture, so they hold through retirement.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      sel      <= '0;
      out_data <= '0;
    end else if (cap) begin
      ptr      <= idx + SEL_W'(1);
      sel      <= idx;
      out_data <= win_data;
    end
  end

  assign out_valid = (st == BUSY);

endmodule

`default_nettype wire
